// File: rtl/rd_path_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rd_path_pkg : shared types, BL codes and window-length helper for the read path
// Revision 1.0
// ----------------------------------------------------------------------------
package rd_path_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2
   } state_e;

   localparam logic [1:0] BL16 = 2'b00;
   localparam logic [1:0] BL8  = 2'b01;
   localparam logic [1:0] BC8  = 2'b10;

   localparam int WIN_W = 4;

   typedef struct packed {
      logic [2:0] pre;
      logic [1:0] bl;
      logic       post;
      logic       crc_en;
      logic       crc_mode;
   } rd_sett_t;

   // Read window in clk cycles; the reserved code behaves like BL16.
   function automatic logic [WIN_W-1:0] win_len(input logic [1:0] bl, input logic crc);
      logic [WIN_W-1:0] w;
      case (bl)
         BL16:     w = 4'd8;
         BL8, BC8: w = 4'd4;
         default:  w = 4'd8;
      endcase
      return w + {3'b000, crc};
   endfunction

endpackage
`default_nettype wire

// File: rtl/rd_cmd_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rd_cmd_fifo : synchronous FIFO holding scheduled read commands
// Revision 1.0
// ----------------------------------------------------------------------------
module rd_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (w_push) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (w_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (w_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (w_push && !w_pop)      cnt_q <= cnt_q + CNT_W'(1);
         else if (w_pop && !w_push) cnt_q <= cnt_q - CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/rd_burst_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rd_burst_scheduler : queues read commands and drives the DFI read window
// Revision 1.0
// ----------------------------------------------------------------------------
module rd_burst_scheduler
   import rd_path_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LAT_W = 6,
   parameter int TS_W  = 8
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             en_i,
   input  logic             rd_req_i,
   output logic             rd_gnt_o,
   input  logic [2:0]       pre_amble_i,
   input  logic [1:0]       bl_i,
   input  logic             post_amble_i,
   input  logic             read_crc_en_i,
   input  logic             phy_crc_mode_i,
   input  logic [LAT_W-1:0] rd_latency_i,
   input  logic             ovf_i,
   output logic             dfi_rddata_en_o,
   output logic [2:0]       pre_amble_sett_o,
   output logic [1:0]       bl_o,
   output logic             post_amble_sett_o,
   output logic             read_crc_enable_o,
   output logic             phy_crc_mode_o,
   output logic             seamless_o,
   output logic             q_full_o,
   output logic             busy_o,
   output logic             err_o
);

   typedef struct packed {
      rd_sett_t         sett;
      logic [WIN_W-1:0] win;
      logic [TS_W-1:0]  start;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   state_e           state_q, state_d;
   logic [TS_W-1:0]  now_q;
   logic [TS_W-1:0]  last_end_q;
   rd_sett_t         sett_q;
   logic [WIN_W-1:0] cnt_q, cnt_d;
   logic             dfi_en_q, dfi_en_d;
   logic             seam_q, seam_d;
   logic             err_q;

   entry_t           w_push_entry;
   entry_t           w_head;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic             w_grant;
   logic             w_pop;
   logic             w_late;
   logic [LAT_W-1:0] w_lat;
   logic [TS_W-1:0]  w_req_time;
   logic [TS_W-1:0]  w_start_diff;
   logic [TS_W-1:0]  w_start;
   logic [WIN_W-1:0] w_win;
   logic [TS_W-1:0]  w_now_p1;
   logic [TS_W-1:0]  w_late_diff;
   logic             w_head_due;

   assign w_grant    = rd_req_i & ~w_fifo_full & en_i;
   assign w_lat      = (rd_latency_i < LAT_W'(2)) ? LAT_W'(2) : rd_latency_i;
   assign w_req_time = now_q + TS_W'(w_lat);
   assign w_win      = win_len(bl_i, read_crc_en_i);
   assign w_now_p1   = now_q + TS_W'(1);

   // Modular compare: last_end is only meaningful while something is queued or in flight.
   assign w_start_diff = w_req_time - last_end_q;
   assign w_start = ((w_fifo_empty && !dfi_en_q) || !w_start_diff[TS_W-1]) ? w_req_time : last_end_q;

   assign w_head_due  = (w_head.start == w_now_p1);
   assign w_late_diff = w_now_p1 - w_head.start;

   assign w_push_entry.sett.pre      = pre_amble_i;
   assign w_push_entry.sett.bl       = bl_i;
   assign w_push_entry.sett.post     = post_amble_i;
   assign w_push_entry.sett.crc_en   = read_crc_en_i;
   assign w_push_entry.sett.crc_mode = phy_crc_mode_i;
   assign w_push_entry.win           = w_win;
   assign w_push_entry.start         = w_start;

   rd_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_cmd_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .flush_i   (~en_i),
      .push_i    (w_grant),
      .pop_i     (w_pop),
      .data_i    (w_push_entry),
      .head_o    (w_head),
      .full_o    (w_fifo_full),
      .empty_o   (w_fifo_empty)
   );

   // Decisions are made one cycle ahead so the registered window rises exactly at head.start.
   always_comb begin
      state_d  = state_q;
      dfi_en_d = dfi_en_q;
      seam_d   = seam_q;
      cnt_d    = cnt_q;
      w_pop    = 1'b0;
      w_late   = 1'b0;
      unique case (state_q)
         IDLE, WAIT: begin
            if (!w_fifo_empty) begin
               if (w_head_due) begin
                  w_pop    = 1'b1;
                  dfi_en_d = 1'b1;
                  seam_d   = 1'b0;
                  cnt_d    = w_head.win;
                  state_d  = BURST;
               end else begin
                  state_d = WAIT;
                  w_late  = !w_late_diff[TS_W-1] && (w_late_diff != '0);
               end
            end else begin
               state_d = w_grant ? WAIT : IDLE;
            end
         end
         BURST: begin
            cnt_d = cnt_q - WIN_W'(1);
            if (cnt_q == WIN_W'(1)) begin
               if (!w_fifo_empty && w_head_due) begin
                  w_pop  = 1'b1;
                  cnt_d  = w_head.win;
                  seam_d = 1'b1;
               end else begin
                  dfi_en_d = 1'b0;
                  seam_d   = 1'b0;
                  state_d  = (!w_fifo_empty || w_grant) ? WAIT : IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= IDLE;
         now_q      <= '0;
         last_end_q <= '0;
         sett_q     <= '0;
         cnt_q      <= '0;
         dfi_en_q   <= 1'b0;
         seam_q     <= 1'b0;
         err_q      <= 1'b0;
      end else if (!en_i) begin
         state_q  <= IDLE;
         dfi_en_q <= 1'b0;
         seam_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         now_q    <= w_now_p1;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dfi_en_q <= dfi_en_d;
         seam_q   <= seam_d;
         err_q    <= err_q | ovf_i | w_late;
         if (w_grant) last_end_q <= w_start + TS_W'(w_win);
         if (w_pop)   sett_q     <= w_head.sett;
      end
   end

   assign rd_gnt_o          = w_grant;
   assign dfi_rddata_en_o   = dfi_en_q;
   assign pre_amble_sett_o  = sett_q.pre;
   assign bl_o              = sett_q.bl;
   assign post_amble_sett_o = sett_q.post;
   assign read_crc_enable_o = sett_q.crc_en;
   assign phy_crc_mode_o    = sett_q.crc_mode;
   assign seamless_o        = seam_q;
   assign q_full_o          = w_fifo_full;
   assign busy_o            = ~w_fifo_empty | dfi_en_q;
   assign err_o             = err_q;

endmodule
`default_nettype wire

// File: doc/rd_burst_scheduler.md
Name: rd_burst_scheduler

Overview:
- Read-path controller placed in front of data_manager.
- Accepts read commands from the controller side and queues their per-read settings: preamble, burst length, postamble, read-CRC enable, PHY CRC mode.
- Schedules each read at a programmable read latency and drives the DFI read-enable window (dfi_rddata_en) and the settings inputs of data_manager.
- Merges back-to-back reads into seamless windows and serialises reads that would overlap.

Parameters:
- DEPTH, 4: command queue entries; legal range 2..6.
- LAT_W, 6: width of the read-latency input; latency range 2..63.
- TS_W, 8: width of the free-running timestamp counter; must satisfy 2^(TS_W-1) > 63 + 9*DEPTH.

Ports:
- clk_i  in  1  system clock.
- reset_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  block enable; low flushes the block.
- rd_req_i  in  1  read command valid.
- rd_gnt_o  out  1  command accepted this cycle (= rd_req_i & !q_full_o & en_i).
- pre_amble_i  in  3  preamble setting of the command.
- bl_i  in  2  burst length code of the command.
- post_amble_i  in  1  postamble setting of the command.
- read_crc_en_i  in  1  read CRC enable of the command.
- phy_crc_mode_i  in  1  PHY CRC mode of the command.
- rd_latency_i  in  LAT_W  read latency in clk cycles, sampled per command.
- ovf_i  in  1  OVF flag from data_manager.
- dfi_rddata_en_o  out  1  read window to data_manager.
- pre_amble_sett_o  out  3  settings of the active burst.
- bl_o  out  2  settings of the active burst.
- post_amble_sett_o  out  1  settings of the active burst.
- read_crc_enable_o  out  1  settings of the active burst.
- phy_crc_mode_o  out  1  settings of the active burst.
- seamless_o  out  1  current burst abuts the previous one.
- q_full_o  out  1  queue holds DEPTH entries.
- busy_o  out  1  queue non-empty or window active.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset: all outputs 0, queue empty, timestamp 0, last_end 0, state IDLE.
- Timestamp: the counter `now` increments every cycle while en_i is high and wraps modulo 2^TS_W. All time comparisons use the signed modular difference (a-b) in TS_W bits.
- Window length W (clk cycles), by bl code:
  - 00 (BL16) = 8
  - 01 (BL8) = 4
  - 10 (BC8) = 4
  - 11 (reserved) = 8
  - read_crc_en adds 1.
- Acceptance: on rd_gnt_o, push an entry {settings, W, start}.
  - start = later of (now + rd_latency_i) and last_end, where last_end is the end time of the most recently accepted command; if the queue is empty and no window is active, start = now + rd_latency_i.
  - Then set last_end = start + W.
  - rd_latency_i < 2 is treated as 2.
- Queue is FIFO. A push while full is impossible because rd_gnt_o is low. A simultaneous push and pop while full is not allowed: full blocks the push.
- FSM:
  - IDLE: queue empty, dfi_rddata_en_o = 0. A push goes to WAIT.
  - WAIT: head pending. When now == head.start, pop the head, load the settings outputs and a window counter with W, assert dfi_rddata_en_o in that same cycle (registered, high from cycle start), and go to BURST.
  - BURST: the window counter decrements each cycle. In the last cycle (counter == 1):
    - if the queue is non-empty and head.start == now+1, pop the head, reload, keep dfi_rddata_en_o high, set seamless_o = 1, stay in BURST;
    - else drop dfi_rddata_en_o the next cycle, set seamless_o = 0, and go to WAIT if the queue is non-empty, else IDLE.
- Settings outputs hold their value after a burst until the next pop, so data_manager sees them stable through the postamble.
- Latency: with an empty block, a command granted at cycle T with latency L gives dfi_rddata_en_o high during cycles T+L .. T+L+W-1.
- err_o: set when ovf_i = 1 at any cycle, or when a head start is already in the past in WAIT (modular difference > 0; this is a defensive check). Cleared only by reset or en_i low.
- en_i low: on the next edge flush the queue, set dfi_rddata_en_o = 0, seamless_o = 0, clear err_o, go to IDLE. The settings outputs keep their values. rd_gnt_o is 0 while en_i is low.
- Reset mid-burst: everything returns to the reset values immediately (asynchronous).

Decomposition:
- Shared package rd_path_pkg holds:
  - state enum {IDLE, WAIT, BURST};
  - BL code constants BL16 = 2'b00, BL8 = 2'b01, BC8 = 2'b10;
  - window length function win_len(bl, crc);
  - the settings struct type (pre, bl, post, crc_en, crc_mode).
- One sub-module, rd_cmd_fifo: a parameterised synchronous FIFO (DEPTH, payload width) with push/pop/full/empty/head.

Test Plan:
- Single read, bl=00, crc=0, L=10, granted at T=5 -> dfi_rddata_en_o high cycles 15..22; settings outputs valid from 15; seamless_o = 0.
- Two reads at T=5 and T=9, L=10, bl=01 -> windows 15..18 and 19..22 merge into one continuous high; seamless_o = 1 during 19..22.
- Overlap: reads at T=5 and T=6, L=10, bl=00, crc=1 (W=9) -> second window is deferred to 24..32; no gap; err_o stays 0.
- Queue full: DEPTH=4, L=63, 5 consecutive requests -> rd_gnt_o low on the 5th; q_full_o = 1; grant resumes one cycle after the first pop.
- ovf_i pulse for 1 cycle mid-burst -> err_o = 1 and stays set; then en_i low for 1 cycle -> err_o = 0, queue empty, dfi_rddata_en_o = 0.
- reset_n_i asserted mid-BURST -> all outputs 0 immediately; after release, a new read with L=2 yields a window at T+2.
